// File: rtl/gray_seq_pkg.sv
// Shared types and helpers for the Gray-code burst sequencer.
package gray_seq_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned MAX_WIDTH     = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Callers cast to and from their own width, which must not exceed MAX_WIDTH
    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gray_encode.sv
// Combinational binary-to-Gray conversion; the output register lives in the caller.
module gray_encode
    import gray_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = WIDTH'(bin2gray(MAX_WIDTH'(bin)));

endmodule

// File: rtl/gray_seq_ctrl.sv
// Burst sequencer emitting one registered Gray code per cycle with pause/abort/done.
// Define GRAY_SEQ_DIR_EN to add the start_dir port for down-counting bursts.
module gray_seq_ctrl
    import gray_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] start_base,
    input  logic [WIDTH-1:0] start_len,
`ifdef GRAY_SEQ_DIR_EN
    input  logic             start_dir,
`endif
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] gray_out,
    output logic             gray_valid,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] cnt_gray;
    logic [WIDTH-1:0] cnt_next;

    gray_encode #(.WIDTH(WIDTH)) u_encode (
        .bin  (cnt),
        .gray (cnt_gray)
    );

`ifdef GRAY_SEQ_DIR_EN
    logic dir;
    assign cnt_next = dir ? (cnt - WIDTH'(1)) : (cnt + WIDTH'(1));
`else
    assign cnt_next = cnt + WIDTH'(1);
`endif

    assign start_ready = (state == IDLE);
    assign busy        = (state != IDLE);

    // Abort beats pause beats emit; a burst ends after the code emitted with rem == 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            rem        <= '0;
            gray_out   <= '0;
            gray_valid <= 1'b0;
            done       <= 1'b0;
`ifdef GRAY_SEQ_DIR_EN
            dir        <= 1'b0;
`endif
        end else begin
            gray_valid <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        cnt   <= start_base;
                        rem   <= start_len;
`ifdef GRAY_SEQ_DIR_EN
                        dir   <= start_dir;
`endif
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= DONE;
                    end else if (pause) begin
                        state <= PAUSE;
                    end else begin
                        gray_out   <= cnt_gray;
                        gray_valid <= 1'b1;
                        cnt        <= cnt_next;
                        rem        <= rem - WIDTH'(1);
                        if (rem == '0) begin
                            state <= DONE;
                        end
                    end
                end
                PAUSE: begin
                    if (abort) begin
                        state <= DONE;
                    end else if (!pause) begin
                        state <= RUN;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
